// File: rtl/blnk_mf_if.sv
// Blank/sync and MISR-control signal bundle for blnk_mf.
// master drives the raw video/control inputs; slave is the blnk_mf block.
interface blnk_mf_if #(
    parameter int NCH    = 3,
    parameter int CNT_W  = 12,
    parameter int DSEL_W = 2,
    parameter int FRM_W  = 4
) ();

    // Inputs to the block
    logic              blankx;
    logic              misr_cntl;
    logic [NCH-1:0]    comp;
    logic [DSEL_W-1:0] dly_sel;
    logic [CNT_W-1:0]  vs_thresh;
    logic [FRM_W-1:0]  frame_cnt;

    // Outputs from the block
    logic              hsync;
    logic              vsync;
    logic              vsync_m1;
    logic              blank_d;
    logic              blank_d2;
    logic [NCH-1:0]    lcomp;
    logic              init_crc;
    logic              enable_crc;
    logic              misr_done;
    logic              misr_busy;

    modport master (
        output blankx, misr_cntl, comp, dly_sel, vs_thresh, frame_cnt,
        input  hsync, vsync, vsync_m1, blank_d, blank_d2, lcomp,
               init_crc, enable_crc, misr_done, misr_busy
    );

    modport slave (
        input  blankx, misr_cntl, comp, dly_sel, vs_thresh, frame_cnt,
        output hsync, vsync, vsync_m1, blank_d, blank_d2, lcomp,
               init_crc, enable_crc, misr_done, misr_busy
    );

endinterface

// File: rtl/blnk_mf.sv
// blnk_mf: blank/sync derivation and MISR capture sequencing in the pixclk domain.
// hsync follows !blankx; vsync/vsync_m1 come from a long blank run; blankx is
// delayed through a selectable pipeline; a small FSM seeds and enables the CRC
// over a programmable number of frames and flags completion.
module blnk_mf #(
    parameter int NCH     = 3,
    parameter int CNT_W   = 12,
    parameter int DLY_MAX = 3,
    parameter int DSEL_W  = 2,
    parameter int FRM_W   = 4
) (
    input logic      pixclk,
    input logic      reset,
    blnk_mf_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   thr_m1;
    logic               thr_nz;
    logic               vsync_r;
    logic               vsync_m1_r;
    logic               vs1;
    logic               vrise;
    logic               vfall;

    logic [3:0]         fix_dly;
    logic [DLY_MAX:0]   tap_v;
    logic [DSEL_W-1:0]  sel_c;
    logic               tap;
    logic               blank_d_r;
    logic               blank_d1;
    logic               blank_d2_r;

    logic [NCH-1:0]     lcomp_r;
    logic [1:0]         msync_ff;
    logic               msync;

    logic [FRM_W-1:0]   rem;
    logic [FRM_W-1:0]   rem_nxt;
    logic               init_crc_c;
    logic               enable_crc_i;
    logic               misr_done_c;
    logic               misr_busy_c;

    assign thr_nz = (bus.vs_thresh != '0);
    assign thr_m1 = bus.vs_thresh - CNT_W'(1);

    // Blank-run length counter: cleared during active video, saturates at all-ones
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (bus.blankx) begin
            run_cnt <= '0;
        end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end

    // vsync and its one-cycle-early twin: set once the run hits the threshold, held until active video
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            vsync_r    <= 1'b0;
            vsync_m1_r <= 1'b0;
        end else if (bus.blankx) begin
            vsync_r    <= 1'b0;
            vsync_m1_r <= 1'b0;
        end else begin
            if (thr_nz && (run_cnt == bus.vs_thresh)) begin
                vsync_r <= 1'b1;
            end
            if (thr_nz && (run_cnt == thr_m1)) begin
                vsync_m1_r <= 1'b1;
            end
        end
    end

    // vsync history for edge detection
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            vs1 <= 1'b0;
        end else begin
            vs1 <= vsync_r;
        end
    end

    assign vrise = vsync_r & ~vs1;
    assign vfall = vs1 & ~vsync_r;

    // Fixed four-stage blank delay
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            fix_dly <= '0;
        end else begin
            fix_dly <= {fix_dly[2:0], bus.blankx};
        end
    end

    assign tap_v[0] = fix_dly[3];

    generate
        if (DLY_MAX > 0) begin : g_ext
            logic [DLY_MAX-1:0] ext;

            // Optional extra stages; the mux below picks how many are used
            always_ff @(posedge pixclk or negedge reset) begin
                if (!reset) begin
                    ext <= '0;
                end else begin
                    ext[0] <= fix_dly[3];
                    for (int unsigned i = 1; i < DLY_MAX; i++) begin
                        ext[i] <= ext[i-1];
                    end
                end
            end

            assign tap_v[DLY_MAX:1] = ext;
        end
    endgenerate

    assign sel_c = (bus.dly_sel > DSEL_W'(DLY_MAX)) ? DSEL_W'(DLY_MAX) : bus.dly_sel;

    // Tap select for the extra delay; tap 0 is the fixed-stage output
    always_comb begin
        tap = tap_v[0];
        for (int unsigned i = 1; i <= DLY_MAX; i++) begin
            if (sel_c == DSEL_W'(i)) begin
                tap = tap_v[i];
            end
        end
    end

    // Output delay stages blank_d -> blank_d1 -> blank_d2
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            blank_d_r  <= 1'b0;
            blank_d1   <= 1'b0;
            blank_d2_r <= 1'b0;
        end else begin
            blank_d_r  <= tap;
            blank_d1   <= blank_d_r;
            blank_d2_r <= blank_d1;
        end
    end

    // Compare bits are tracked during delayed blanking and frozen during active video
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            lcomp_r <= '0;
        end else if (!blank_d1) begin
            lcomp_r <= bus.comp;
        end
    end

    // Two-flop synchroniser for the asynchronous MISR request
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            msync_ff <= '0;
        end else begin
            msync_ff <= {msync_ff[0], bus.misr_cntl};
        end
    end

    assign msync = msync_ff[1];

    // MISR FSM state and remaining-frame register
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // MISR FSM next state and Moore outputs; abort outranks a coincident vrise
    always_comb begin
        state_nxt    = state;
        rem_nxt      = rem;
        init_crc_c   = 1'b0;
        enable_crc_i = 1'b0;
        misr_done_c  = 1'b0;
        misr_busy_c  = 1'b0;
        case (state)
            IDLE: begin
                if (vfall && msync) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                init_crc_c  = 1'b1;
                misr_busy_c = 1'b1;
                rem_nxt     = (bus.frame_cnt == '0) ? FRM_W'(1) : bus.frame_cnt;
                state_nxt   = RUN;
            end
            RUN: begin
                enable_crc_i = 1'b1;
                misr_busy_c  = 1'b1;
                if (!msync) begin
                    state_nxt = IDLE;
                end else if (vrise) begin
                    if (rem <= FRM_W'(1)) begin
                        state_nxt = DONE;
                    end else begin
                        rem_nxt = rem - FRM_W'(1);
                    end
                end
            end
            DONE: begin
                misr_done_c = 1'b1;
                if (vfall) begin
                    state_nxt = msync ? INIT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.hsync      = ~bus.blankx;
    assign bus.vsync      = vsync_r;
    assign bus.vsync_m1   = vsync_m1_r;
    assign bus.blank_d    = blank_d_r;
    assign bus.blank_d2   = blank_d2_r;
    assign bus.lcomp      = lcomp_r;
    assign bus.init_crc   = init_crc_c;
    assign bus.enable_crc = enable_crc_i & blank_d2_r;
    assign bus.misr_done  = misr_done_c;
    assign bus.misr_busy  = misr_busy_c;

endmodule

// File: tb/tb_blnk_mf.sv
// Testbench for blnk_mf: per-scenario tasks with queue-based expected values.
module tb_blnk_mf;

    localparam int NCH    = 3;
    localparam int CNT_W  = 12;
    localparam int DSEL_W = 2;
    localparam int FRM_W  = 4;

    typedef struct packed {
        logic m1;
        logic v;
    } vexp_t;

    typedef struct packed {
        logic init;
        logic busy;
        logic done;
        logic en;
    } mexp_t;

    logic        pixclk = 1'b0;
    logic        reset;
    int unsigned n_vec;
    int unsigned n_err;

    always #5 pixclk = ~pixclk;

    blnk_mf_if #(.NCH(NCH), .CNT_W(CNT_W), .DSEL_W(DSEL_W), .FRM_W(FRM_W)) bus ();
    blnk_mf_if #(.NCH(NCH), .CNT_W(CNT_W), .DSEL_W(DSEL_W), .FRM_W(FRM_W)) bus2 ();

    blnk_mf #(
        .NCH(NCH), .CNT_W(CNT_W), .DLY_MAX(3), .DSEL_W(DSEL_W), .FRM_W(FRM_W)
    ) dut (
        .pixclk(pixclk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance with a shallower delay line to exercise dly_sel clamping
    blnk_mf #(
        .NCH(NCH), .CNT_W(CNT_W), .DLY_MAX(2), .DSEL_W(DSEL_W), .FRM_W(FRM_W)
    ) dut2 (
        .pixclk(pixclk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.blankx    = bus.blankx;
    assign bus2.misr_cntl = bus.misr_cntl;
    assign bus2.comp      = bus.comp;
    assign bus2.dly_sel   = bus.dly_sel;
    assign bus2.vs_thresh = bus.vs_thresh;
    assign bus2.frame_cnt = bus.frame_cnt;

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic bpat(input int x);
        return (x < 0) || ((x % 16) < 8);
    endfunction

    function automatic logic in_rng(input int s, input int lo, input int hi);
        return (s >= lo) && (s <= hi);
    endfunction

    task automatic test_reset();
        logic            exp_q[$];
        logic            e;
        logic            b;
        logic [NCH+7:0]  o;
        reset         = 1'b0;
        bus.misr_cntl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b          = ((i % 3) != 0);
            bus.blankx = b;
            bus.comp   = NCH'($urandom);
            exp_q.push_back(~b);
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.hsync !== e) begin
                n_err++;
                $display("FAIL reset_hsync i=%0d got=%b exp=%b", i, bus.hsync, e);
            end
            o = {bus.vsync, bus.vsync_m1, bus.blank_d, bus.blank_d2, bus.lcomp,
                 bus.init_crc, bus.enable_crc, bus.misr_done, bus.misr_busy};
            n_vec++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL reset_outs i=%0d got=%b exp=0", i, o);
            end
            o = {bus2.vsync, bus2.vsync_m1, bus2.blank_d, bus2.blank_d2, bus2.lcomp,
                 bus2.init_crc, bus2.enable_crc, bus2.misr_done, bus2.misr_busy};
            n_vec++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL reset_outs2 i=%0d got=%b exp=0", i, o);
            end
        end
        bus.blankx    = 1'b1;
        bus.misr_cntl = 1'b0;
        reset         = 1'b1;
        tick();
    endtask

    task automatic test_vsync();
        int    thr_t[4] = '{10, 1, 0, 20};
        int    m1s_t[4] = '{10, 1, 0, 20};
        int    vs_t[4]  = '{11, 2, 0, 0};
        vexp_t q[$];
        vexp_t e;
        for (int r = 0; r < 4; r++) begin
            bus.vs_thresh = CNT_W'(thr_t[r]);
            bus.blankx    = 1'b1;
            repeat (3) tick();
            for (int i = 1; i <= 24; i++) begin
                bus.blankx = (i > 20);
                e.m1 = (m1s_t[r] != 0) && (i >= m1s_t[r]) && (i <= 20);
                e.v  = (vs_t[r] != 0) && (i >= vs_t[r]) && (i <= 20);
                q.push_back(e);
                tick();
                e = q.pop_front();
                n_vec++;
                if (bus.vsync_m1 !== e.m1) begin
                    n_err++;
                    $display("FAIL vsync_m1 thr=%0d i=%0d got=%b exp=%b", thr_t[r], i, bus.vsync_m1, e.m1);
                end
                n_vec++;
                if (bus.vsync !== e.v) begin
                    n_err++;
                    $display("FAIL vsync thr=%0d i=%0d got=%b exp=%b", thr_t[r], i, bus.vsync, e.v);
                end
            end
        end
        bus.vs_thresh = '0;
    endtask

    task automatic test_delay();
        int   dsel_t[4] = '{0, 3, 1, 2};
        int   l1_t[4]   = '{5, 8, 6, 7};
        int   l2_t[4]   = '{5, 7, 6, 7};
        logic q1[$];
        logic q2[$];
        logic q3[$];
        logic b;
        logic e;
        for (int r = 0; r < 4; r++) begin
            bus.dly_sel = DSEL_W'(dsel_t[r]);
            bus.blankx  = 1'b1;
            repeat (12) tick();
            q1.delete();
            q2.delete();
            q3.delete();
            for (int n = 0; n < 48; n++) begin
                b          = ($urandom_range(1, 0) != 0);
                bus.blankx = b;
                q1.push_back(b);
                q2.push_back(b);
                q3.push_back(b);
                tick();
                if (q1.size() == l1_t[r]) begin
                    e = q1.pop_front();
                    n_vec++;
                    if (bus.blank_d !== e) begin
                        n_err++;
                        $display("FAIL blank_d dsel=%0d n=%0d got=%b exp=%b", dsel_t[r], n, bus.blank_d, e);
                    end
                end
                if (q3.size() == l1_t[r] + 2) begin
                    e = q3.pop_front();
                    n_vec++;
                    if (bus.blank_d2 !== e) begin
                        n_err++;
                        $display("FAIL blank_d2 dsel=%0d n=%0d got=%b exp=%b", dsel_t[r], n, bus.blank_d2, e);
                    end
                end
                if (q2.size() == l2_t[r]) begin
                    e = q2.pop_front();
                    n_vec++;
                    if (bus2.blank_d !== e) begin
                        n_err++;
                        $display("FAIL blank_d_clamp dsel=%0d n=%0d got=%b exp=%b", dsel_t[r], n, bus2.blank_d, e);
                    end
                end
            end
        end
        bus.dly_sel = '0;
        bus.blankx  = 1'b1;
    endtask

    task automatic test_lcomp();
        logic           bh[40];
        logic [NCH-1:0] q[$];
        logic [NCH-1:0] exp_l;
        logic [NCH-1:0] c;
        logic           b;
        bus.dly_sel = '0;
        bus.blankx  = 1'b1;
        bus.comp    = '0;
        pulse_reset();
        repeat (10) tick();
        exp_l = '0;
        for (int t = 0; t < 40; t++) begin
            b          = !((t >= 8) && (t < 20));
            bh[t]      = b;
            c          = NCH'($urandom);
            bus.blankx = b;
            bus.comp   = c;
            if ((t >= 6) && (bh[t-6] == 1'b0)) begin
                exp_l = c;
            end
            q.push_back(exp_l);
            tick();
            exp_l = q.pop_front();
            n_vec++;
            if (bus.lcomp !== exp_l) begin
                n_err++;
                $display("FAIL lcomp t=%0d got=%b exp=%b", t, bus.lcomp, exp_l);
            end
        end
        bus.blankx = 1'b1;
    endtask

    task automatic test_multi_frame();
        mexp_t q[$];
        mexp_t e;
        mexp_t o;
        int    s;
        bus.dly_sel   = '0;
        bus.vs_thresh = CNT_W'(3);
        bus.frame_cnt = FRM_W'(3);
        bus.misr_cntl = 1'b1;
        bus.blankx    = 1'b1;
        pulse_reset();
        for (int t = 0; t < 80; t++) begin
            bus.blankx = bpat(t);
            s      = t + 1;
            e.init = (s == 18) || (s == 66);
            e.busy = in_rng(s, 18, 60) || (s >= 66);
            e.done = in_rng(s, 61, 65);
            e.en   = (in_rng(s, 19, 60) || (s >= 67)) && bpat(s - 7);
            q.push_back(e);
            tick();
            e = q.pop_front();
            o = {bus.init_crc, bus.misr_busy, bus.misr_done, bus.enable_crc};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL multi_frame s=%0d got(init,busy,done,en)=%b exp=%b", s, o, e);
            end
        end
    endtask

    task automatic test_frame_zero();
        mexp_t q[$];
        mexp_t e;
        mexp_t o;
        int    s;
        bus.vs_thresh = CNT_W'(3);
        bus.frame_cnt = '0;
        bus.misr_cntl = 1'b1;
        bus.blankx    = 1'b1;
        pulse_reset();
        for (int t = 0; t < 40; t++) begin
            bus.blankx = bpat(t);
            s      = t + 1;
            e.init = (s == 18) || (s == 34);
            e.busy = in_rng(s, 18, 28) || (s >= 34);
            e.done = in_rng(s, 29, 33);
            e.en   = (in_rng(s, 19, 28) || (s >= 35)) && bpat(s - 7);
            q.push_back(e);
            tick();
            e = q.pop_front();
            o = {bus.init_crc, bus.misr_busy, bus.misr_done, bus.enable_crc};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL frame_zero s=%0d got(init,busy,done,en)=%b exp=%b", s, o, e);
            end
        end
    endtask

    task automatic test_abort();
        mexp_t q[$];
        mexp_t e;
        mexp_t o;
        int    s;
        bus.vs_thresh = CNT_W'(3);
        bus.frame_cnt = FRM_W'(2);
        bus.misr_cntl = 1'b1;
        bus.blankx    = 1'b1;
        pulse_reset();
        for (int t = 0; t < 64; t++) begin
            bus.blankx = bpat(t);
            if (t == 30) begin
                bus.misr_cntl = 1'b0;
            end
            s      = t + 1;
            e.init = (s == 18);
            e.busy = in_rng(s, 18, 32);
            e.done = 1'b0;
            e.en   = in_rng(s, 19, 32) && bpat(s - 7);
            q.push_back(e);
            tick();
            e = q.pop_front();
            o = {bus.init_crc, bus.misr_busy, bus.misr_done, bus.enable_crc};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL abort s=%0d got(init,busy,done,en)=%b exp=%b", s, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        mexp_t q[$];
        mexp_t e;
        mexp_t o;
        int    s;
        bus.vs_thresh = CNT_W'(3);
        bus.frame_cnt = FRM_W'(3);
        bus.misr_cntl = 1'b1;
        bus.blankx    = 1'b1;
        pulse_reset();
        for (int t = 0; t < 80; t++) begin
            bus.blankx = bpat(t);
            if (t == 30) begin
                reset = 1'b0;
            end
            if (t == 33) begin
                reset = 1'b1;
            end
            s      = t + 1;
            e.init = (s == 18) || (s == 50);
            e.busy = in_rng(s, 18, 30) || in_rng(s, 50, 80);
            e.done = 1'b0;
            e.en   = (in_rng(s, 19, 30) || in_rng(s, 51, 80)) && bpat(s - 7);
            q.push_back(e);
            tick();
            e = q.pop_front();
            o = {bus.init_crc, bus.misr_busy, bus.misr_done, bus.enable_crc};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_mid_run s=%0d got(init,busy,done,en)=%b exp=%b", s, o, e);
            end
        end
        bus.misr_cntl = 1'b0;
    endtask

    task automatic test_saturation();
        vexp_t q[$];
        vexp_t e;
        vexp_t o;
        bus.misr_cntl = 1'b0;
        bus.vs_thresh = '0;
        bus.blankx    = 1'b1;
        pulse_reset();
        repeat (2) tick();
        for (int i = 1; i <= 5000; i++) begin
            bus.blankx = 1'b0;
            if (i == 4401) begin
                bus.vs_thresh = CNT_W'(4095);
            end
            e.m1 = 1'b0;
            e.v  = (i >= 4401);
            q.push_back(e);
            tick();
            e = q.pop_front();
            o = {bus.vsync_m1, bus.vsync};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL saturation i=%0d got(m1,v)=%b exp=%b", i, o, e);
            end
        end
        bus.blankx = 1'b1;
        tick();
        n_vec++;
        if (bus.vsync !== 1'b0) begin
            n_err++;
            $display("FAIL sat_clear got=%b exp=0", bus.vsync);
        end
        bus.vs_thresh = '0;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b0;
        bus.blankx    = 1'b1;
        bus.misr_cntl = 1'b0;
        bus.comp      = '0;
        bus.dly_sel   = '0;
        bus.vs_thresh = '0;
        bus.frame_cnt = '0;
        test_reset();
        test_vsync();
        test_delay();
        test_lcomp();
        test_multi_frame();
        test_frame_zero();
        test_abort();
        test_reset_mid_run();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
